// File: rtl/mult_div_ctrl.sv
// Iterative signed multiply/divide sequencer: shift-add multiply or restoring
// divide on operand magnitudes, then sign fixup into the HI/LO registers.
module mult_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MULT  = 3'd1;
    localparam logic [2:0] S_DIV   = 3'd2;
    localparam logic [2:0] S_FIXUP = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               is_div_q, is_div_d;
    logic               div_zero_q, div_zero_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mult_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic               last_step;
    logic               neg_res;

    // Magnitudes as unsigned values; the most negative input maps onto itself.
    assign abs_a = a[WIDTH-1] ? -a : a;
    assign abs_b = b[WIDTH-1] ? -b : b;

    // Multiply step: conditional add into the upper half with carry kept.
    assign mult_sum = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q})
                               : {1'b0, acc_q[2*WIDTH-1:WIDTH]};

    // Divide step: acc holds {rem, quot}; shift one dividend bit into rem.
    assign rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, opnd_q};

    assign neg_res   = sign_a_q ^ sign_b_q;
    assign prod_fix  = neg_res ? -acc_q : acc_q;
    assign last_step = (cnt_q == CW'(WIDTH - 1));

    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        is_div_d   = is_div_q;
        div_zero_d = div_zero_q;

        case (state_q)
            S_IDLE: begin
                if (start_mult || start_div) begin
                    sign_a_d   = a[WIDTH-1];
                    sign_b_d   = b[WIDTH-1];
                    cnt_d      = '0;
                    div_zero_d = 1'b0;
                    if (start_mult) begin
                        state_d  = S_MULT;
                        is_div_d = 1'b0;
                        opnd_d   = abs_a;
                        acc_d    = {{WIDTH{1'b0}}, abs_b};
                    end else if (b == '0) begin
                        state_d    = S_DONE;
                        is_div_d   = 1'b1;
                        div_zero_d = 1'b1;
                    end else begin
                        state_d  = S_DIV;
                        is_div_d = 1'b1;
                        opnd_d   = abs_b;
                        acc_d    = {{WIDTH{1'b0}}, abs_a};
                    end
                end
            end
            S_MULT: begin
                acc_d = {mult_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (last_step) state_d = S_FIXUP;
            end
            S_DIV: begin
                if (!trial[WIDTH]) acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                else               acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (last_step) state_d = S_FIXUP;
            end
            S_FIXUP: begin
                if (is_div_q) begin
                    lo_d = neg_res  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            is_div_q   <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            is_div_q   <= is_div_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl: directed corner cases plus random
// operations compared against a plain-arithmetic signed reference model.
module tb_mult_div_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_mult = 1'b0;
    logic        start_div = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;
    logic        dz_m = 1'b0;

    mult_div_ctrl #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: signed arithmetic on 64-bit integers.
    task automatic model_op(input bit is_mult, input logic [31:0] ai, input logic [31:0] bi,
                            output int exp_lat);
        longint sa, sb, p, q, r;
        sa = longint'($signed(ai));
        sb = longint'($signed(bi));
        if (is_mult) begin
            p = sa * sb;
            hi_m = p[63:32];
            lo_m = p[31:0];
            dz_m = 1'b0;
            exp_lat = 33;
        end else if (bi == 32'd0) begin
            dz_m = 1'b1;
            exp_lat = 0;
        end else begin
            q = sa / sb;
            r = sa % sb;
            lo_m = q[31:0];
            hi_m = r[31:0];
            dz_m = 1'b0;
            exp_lat = 33;
        end
    endtask

    task automatic start_op(input bit sm, input bit sd, input logic [31:0] ai, input logic [31:0] bi);
        @(negedge clk);
        a = ai;
        b = bi;
        start_mult = sm;
        start_div = sd;
        @(posedge clk);
        #1;
        start_mult = 1'b0;
        start_div = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    // Waits for done; optionally pulses start_div (b=0) inside the run.
    task automatic wait_done(input int inject_at, output int lat, output int busy_cycles, output bit got);
        lat = -1;
        busy_cycles = 0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) begin
                lat = i;
                got = 1'b1;
                break;
            end
            if (i == inject_at) begin
                b = 32'd0;
                start_div = 1'b1;
            end else begin
                start_div = 1'b0;
            end
        end
        start_div = 1'b0;
    endtask

    task automatic run_op(input string tag, input bit sm, input bit sd,
                          input logic [31:0] ai, input logic [31:0] bi, input int inject_at);
        int exp_lat, lat, bc;
        bit got;
        model_op(sm, ai, bi, exp_lat);
        start_op(sm, sd, ai, bi);
        wait_done(inject_at, lat, bc, got);
        check({tag, " done_seen"}, 64'(got), 64'd1);
        if (got) begin
            check({tag, " latency"}, 64'(lat), 64'(exp_lat));
            check({tag, " hi"}, 64'(hi), 64'(hi_m));
            check({tag, " lo"}, 64'(lo), 64'(lo_m));
            check({tag, " div_zero"}, 64'(div_zero), 64'(dz_m));
            @(negedge clk);
            check({tag, " busy_cycles"}, 64'(bc), 64'(exp_lat + 1));
            check({tag, " idle_after"}, {62'd0, busy, done}, 64'd0);
        end
    endtask

    initial begin
        int lat, bc;
        bit got;
        logic [31:0] ra, rb;

        // Reset state
        #12;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst div_zero", 64'(div_zero), 64'd0);
        check("rst hi", 64'(hi), 64'd0);
        check("rst lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mult 7*-3", 1, 0, 32'd7, 32'hFFFF_FFFD, -1);
        run_op("mult min*min", 1, 0, 32'h8000_0000, 32'h8000_0000, -1);
        run_op("mult 0*x", 1, 0, 32'd0, 32'h1234_5678, -1);
        run_op("div -7/2", 0, 1, 32'hFFFF_FFF9, 32'd2, -1);
        run_op("div 7/-2", 0, 1, 32'd7, 32'hFFFF_FFFE, -1);
        run_op("div min/-1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op("div by zero", 0, 1, 32'd1234, 32'd0, -1);
        run_op("mult clears dz", 1, 0, 32'hFFFF_0001, 32'd99, -1);
        run_op("both starts", 1, 1, 32'd100, 32'hFFFF_FFF6, -1);
        run_op("mult with div pulse", 1, 0, 32'h0001_2345, 32'h0000_6789, 10);

        // Asynchronous reset in the middle of a divide
        start_op(0, 1, 32'd1000, 32'd7);
        repeat (15) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        check("abort div_zero", 64'(div_zero), 64'd0);
        hi_m = '0;
        lo_m = '0;
        dz_m = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        run_op("mult 3*5 after reset", 1, 0, 32'd3, 32'd5, -1);

        // Random operations, with occasional corner operands
        for (int k = 0; k < 24; k++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = $urandom_range(1, 9);
                default: ;
            endcase
            if ($urandom_range(0, 1) == 0) run_op("rand mult", 1, 0, ra, rb, -1);
            else                           run_op("rand div", 0, 1, ra, rb, -1);
        end

        // Bounded wait already guaranteed; one final consistency look
        wait_done(-1, lat, bc, got);
        check("no spurious done", 64'(got), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
